// File: rtl/arbitro_memoria_dados.sv
// Two-port arbiter and sequencer in front of a single-port data memory with registered read.
// Grants at most one access every two cycles, returns read data with a strobe and flags out-of-range words.
module arbitro_memoria_dados #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int RAM_WORDS  = 1024,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              err0,
    output logic              err1,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_datain,
    input  logic [DATA_W-1:0] mem_dataout,
    output logic              state_dbg
);
    // Handshake: a port raises req with we/addr/wdata and holds them until its one-cycle gnt;
    // requests are sampled only in IDLE, the access happens in the gnt cycle, reads return with rvalid one cycle later.
    typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

    localparam logic [ADDR_W:0] RAM_LIMIT = (ADDR_W+1)'(RAM_WORDS);

    state_t            state;
    logic              last_win;
    logic              win;
    logic              acc_we;
    logic              acc_oor;
    logic              rd_oor;

    logic              sel;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_oor;

    // sel = 1 means port 1 wins the current arbitration.
    always_comb begin
        sel = 1'b0;
        if (req0 && req1) begin
            if (FIXED_PRIO != 0) begin
                sel = 1'b0;
            end else begin
                sel = ~last_win;
            end
        end else begin
            sel = req1;
        end
    end

    always_comb begin
        sel_we    = sel ? we1    : we0;
        sel_addr  = sel ? addr1  : addr0;
        sel_wdata = sel ? wdata1 : wdata0;
        sel_oor   = ({1'b0, sel_addr} >= RAM_LIMIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            rvalid0    <= 1'b0;
            rvalid1    <= 1'b0;
            err0       <= 1'b0;
            err1       <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_datain <= '0;
            last_win   <= 1'b1;
            win        <= 1'b0;
            acc_we     <= 1'b0;
            acc_oor    <= 1'b0;
            rd_oor     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    rvalid0 <= 1'b0;
                    rvalid1 <= 1'b0;
                    if (req0 || req1) begin
                        state      <= ACCESS;
                        win        <= sel;
                        gnt0       <= ~sel;
                        gnt1       <= sel;
                        mem_addr   <= sel_addr;
                        mem_datain <= sel_wdata;
                        mem_we     <= sel_we & ~sel_oor;
                        err0       <= ~sel & sel_oor;
                        err1       <= sel & sel_oor;
                        acc_we     <= sel_we;
                        acc_oor    <= sel_oor;
                    end
                end
                ACCESS: begin
                    // The memory captures the write / presents read data on this closing edge.
                    state    <= IDLE;
                    gnt0     <= 1'b0;
                    gnt1     <= 1'b0;
                    err0     <= 1'b0;
                    err1     <= 1'b0;
                    mem_we   <= 1'b0;
                    last_win <= win;
                    rvalid0  <= ~acc_we & ~win;
                    rvalid1  <= ~acc_we & win;
                    rd_oor   <= acc_oor;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Read data comes straight from the registered memory output, masked outside the strobe and for bad addresses.
    assign rdata0    = (rvalid0 && !rd_oor) ? mem_dataout : '0;
    assign rdata1    = (rvalid1 && !rd_oor) ? mem_dataout : '0;
    assign state_dbg = (state == ACCESS);

endmodule
